// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key schedule constants, state encoding and Rcon lookup
package aes_pkg;
  localparam int NR = 10;
  localparam int KW = 128;
  typedef enum logic {IDLE, EXPAND} state_t;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/key_round_step.sv
// key_round_step: one combinational AES-128 key expansion round
module key_round_step
  import aes_pkg::*;
(
  input  logic [3:0]    round,
  input  logic [KW-1:0] key_in,
  output logic [KW-1:0] key_out
);
  logic [31:0] w_rot, w_sub, w_tmp, w0, w1, w2, w3;
  assign w_rot = {key_in[23:0], key_in[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_sb
    sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
  end
  assign w_tmp = w_sub ^ {rcon(round), 24'h0};
  assign w0 = key_in[127:96] ^ w_tmp;
  assign w1 = key_in[95:64] ^ w0;
  assign w2 = key_in[63:32] ^ w1;
  assign w3 = key_in[31:0] ^ w2;
  assign key_out = {w0, w1, w2, w3};
endmodule

// File: rtl/sbox.sv
// sbox: AES forward substitution box, one byte in, one byte out
module sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_s = SBOX[i_a];
endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: sequences AES-128 key expansion one round per clock into an 11-entry
// round-key table and serves entries through a registered read port.
module key_sched_ctrl
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic          busy,
  output logic          done,
  output logic          key_valid,
  input  logic [3:0]    rd_idx,
  output logic [KW-1:0] rd_key
);
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [KW-1:0] r_tab [0:NR];
  logic          r_busy, r_done, r_valid;
  logic [KW-1:0] r_rd_key;
  logic [3:0]    w_prev_idx;
  logic [KW-1:0] w_step;
  assign w_prev_idx = r_cnt - 4'd1;
  key_round_step u_step (.round(r_cnt), .key_in(r_tab[w_prev_idx]), .key_out(w_step));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_rd_key <= '0;
      for (int i = 0; i <= NR; i++) r_tab[i] <= '0;
    end else begin
      r_rd_key <= (rd_idx <= 4'(NR)) ? r_tab[rd_idx] : '0;
      r_done   <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_tab[0] <= key_in;
          r_cnt    <= 4'd1;
          r_valid  <= 1'b0;
          r_busy   <= 1'b1;
          r_state  <= EXPAND;
        end
      end else begin
        r_tab[r_cnt] <= w_step;
        if (r_cnt == 4'(NR)) begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end
  assign busy      = r_busy;
  assign done      = r_done;
  assign key_valid = r_valid;
  assign rd_key    = r_rd_key;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: randomized self-checking bench against a FIPS-197 style key expansion model
module tb_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         rst, start, busy, done, key_valid;
  logic [127:0] key_in, rd_key;
  logic [3:0]   rd_idx;
  int checks = 0, errors = 0;
  logic [7:0] sb [256];
  typedef logic [127:0] ks_t [11];

  always #5 clk = ~clk;

  key_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .done(done), .key_valid(key_valid), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map
  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic ks_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    ks_t ks;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) ks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return ks;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts edges until done is seen (returns -1 after 30 edges without it)
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 30 && n < 0; i++) begin
      tick();
      if (done) n = i;
    end
  endtask

  task automatic launch(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b key_valid=%b required 0 0 0", busy, done, key_valid);
    end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      tick();
      checks++;
      if (rd_key !== 128'h0) begin
        errors++;
        $display("FAIL reset_read idx=%0d got %h required 0", i, rd_key);
      end
    end
  endtask

  task automatic test_fips();
    ks_t exp_ks;
    int n;
    logic [127:0] k;
    for (int trial = 0; trial < 4; trial++) begin
      k = (trial == 0) ? 128'h2b7e151628aed2a6abf7158809cf4f3c
                       : {$urandom, $urandom, $urandom, $urandom};
      exp_ks = expand(k);
      launch(k);
      checks++;
      if (busy !== 1'b1 || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_accept busy=%b key_valid=%b required 1 0", busy, key_valid);
      end
      wait_done(n);
      checks++;
      if (n != 10) begin
        errors++;
        $display("FAIL done_latency got %0d edges required 10", n);
      end
      checks++;
      if (key_valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_done key_valid=%b busy=%b required 1 0", key_valid, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_width done=%b one cycle later required 0", done);
      end
      for (int i = 0; i <= 10; i++) begin
        rd_idx = 4'(i);
        tick();
        checks++;
        if (rd_key !== exp_ks[i]) begin
          errors++;
          $display("FAIL sched_read key=%h idx=%0d got %h required %h", k, i, rd_key, exp_ks[i]);
        end
        if (trial == 0 && (i == 1 || i == 2 || i == 10)) begin
          checks++;
          if (rd_key !== (i == 1 ? 128'ha0fafe1788542cb123a339392a6c7605 :
                          i == 2 ? 128'hf2c295f27a96b9435935807a7359f67f :
                                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin
            errors++;
            $display("FAIL fips_vector idx=%0d got %h", i, rd_key);
          end
        end
      end
    end
  endtask

  task automatic test_busy_start();
    logic [127:0] ka, kb;
    ks_t exp_ks;
    int pulses = 0;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    exp_ks = expand(ka);
    launch(ka);
    tick();
    tick();
    tick();
    key_in = kb;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    if (done) pulses++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL busy_start_pulses got %0d required 1", pulses);
    end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      tick();
      checks++;
      if (rd_key !== exp_ks[i]) begin
        errors++;
        $display("FAIL busy_start_read idx=%0d got %h required %h", i, rd_key, exp_ks[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    launch({$urandom, $urandom, $urandom, $urandom});
    wait_done(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL b2b_first_done got %0d edges required 10", n);
    end
    launch(128'h000102030405060708090a0b0c0d0e0f);
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept key_valid=%b busy=%b required 0 1", key_valid, busy);
    end
    wait_done(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL b2b_second_done got %0d edges required 10", n);
    end
    rd_idx = 4'd10;
    tick();
    checks++;
    if (rd_key !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++;
      $display("FAIL b2b_rk10 got %h required 13111d7fe3944a17f307a78b4d2b30c5", rd_key);
    end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    launch({$urandom, $urandom, $urandom, $urandom});
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || key_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags busy=%b key_valid=%b done=%b required 0 0 0", busy, key_valid, done);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_reset_done got %0d pulses required 0", pulses);
    end
    rd_idx = 4'd1;
    tick();
    checks++;
    if (rd_key !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset_read got %h required 0", rd_key);
    end
  endtask

  task automatic test_oob();
    logic [127:0] k;
    ks_t exp_ks;
    int n;
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_ks = expand(k);
    launch(k);
    wait_done(n);
    for (int j = 0; j < 2; j++) begin
      rd_idx = 4'd10;
      tick();
      checks++;
      if (rd_key !== exp_ks[10]) begin
        errors++;
        $display("FAIL oob_prior got %h required %h", rd_key, exp_ks[10]);
      end
      rd_idx = (j == 0) ? 4'd11 : 4'd15;
      tick();
      checks++;
      if (rd_key !== 128'h0) begin
        errors++;
        $display("FAIL oob_read idx=%0d got %h required 0", rd_idx, rd_key);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    rd_idx = '0;
    init_sbox();
    test_reset();
    test_fips();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    test_oob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
- Sequences AES-128 key expansion for the encrypt core.
- Accepts a 128-bit cipher key on a start pulse and iterates the single-round expansion step over rounds 1..10, one round per clock.
- Stores all 11 round keys (index 0 = cipher key) in an internal table.
- Serves round keys to the cipher datapath through a registered read port indexed by round.

Parameters:
- NR, 10, number of expansion rounds (fixed at 10 for AES-128; other values unsupported).
- KW, 128, key/round-key width in bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to expand key_in; sampled only in IDLE.
- key_in  in  128  cipher key, sampled on the edge where start is accepted.
- busy  out  1  high while expansion is in progress.
- done  out  1  one-cycle pulse when round key 10 is written.
- key_valid  out  1  high while the table holds a complete schedule for the last accepted key.
- rd_idx  in  4  round-key index to read (0..10).
- rd_key  out  128  registered round key for rd_idx.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - State IDLE; busy=0, done=0, key_valid=0, rd_key=0.
  - Round counter=0; all 11 table entries cleared to 0.
- States: IDLE, EXPAND.
- IDLE:
  - start=1 at edge T: table[0]<=key_in, round counter<=1, key_valid<=0, busy<=1, go to EXPAND.
  - start=0: hold.
- EXPAND, at each edge with counter=r:
  - table[r] <= step(table[r-1], r).
  - If r==10: done<=1, key_valid<=1, busy<=0, go to IDLE.
  - Otherwise counter<=r+1.
- Latency: rk1 written at T+1, rk10 at T+10. done is high in the cycle following edge T+10 only (exactly one cycle).
- start while in EXPAND: ignored, no queuing; key_in ignored.
- start in the cycle done is high (state IDLE): accepted normally; key_valid returns to 0 at that edge.
- Step function:
  - Temp = RotWord(w3), then SubWord via sbox, then XOR Rcon[r] into the MSB byte.
  - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Word 0 is key[127:96].
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (upper byte of word; lower 24 bits zero).
- Read port:
  - rd_key <= table[rd_idx] every edge; 1-cycle latency; available in all states.
  - rd_idx 11..15 returns 128'h0.
  - Reads during EXPAND return current table contents, which are partially updated. The consumer must qualify with key_valid.
- Reset mid-expansion: returns to IDLE within the same edge with the table cleared; no done pulse.
- No arithmetic other than XOR; counter is 4 bits; no wrap beyond 10.

Decomposition:
- Shared package `aes_pkg`:
  - Constants NR=10, KW=128.
  - Rcon lookup function.
  - State enum {IDLE, EXPAND}.
- Sub-module `key_round_step`:
  - Combinational; inputs round[3:0], key_in[127:0]; output key_out[127:0].
  - Instantiates 4 `sbox` instances for SubWord.
  - Controller contains one instance, time-multiplexed across rounds.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst 2 cycles, release, read all rd_idx 0..10.
  - Required: busy=0, done=0, key_valid=0, every rd_key=0.
- FIPS-197 vector:
  - Stimulus: start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: done exactly 10 cycles after acceptance, then key_valid=1.
  - Required reads: rd_idx=0→2b7e1516..., 1→a0fafe1788542cb123a339392a6c7605, 2→f2c295f27a96b9435935807a7359f67f, 10→d014f9a8c9ee2589e13f0cc8b6630ca6.
- Start during busy:
  - Stimulus: pulse start with a different key at cycle T+4.
  - Required: ignored; table matches the original-key schedule; single done pulse.
- Back-to-back:
  - Stimulus: start asserted in the done cycle with key 000102030405060708090a0b0c0d0e0f.
  - Required: key_valid falls; after 10 cycles rd_idx=10 returns 13111d7fe3944a17f307a78b4d2b30c5.
- Mid-run reset:
  - Stimulus: rst at T+5.
  - Required: busy=0 next cycle, no done pulse, key_valid=0, rd_idx=1 returns 0.
- Out-of-range read:
  - Stimulus: rd_idx=11 and rd_idx=15 after a valid schedule.
  - Required: rd_key=0, one cycle after rd_idx is applied.
